// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: width codes, FSM states and request legality.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} mem_rsp_state_t;

    typedef struct packed {
        logic misaligned;
        logic illegal_f3;
    } req_chk_t;

    // Range checking depends on the RAM depth, so it lives in the top level.
    function automatic req_chk_t legal_req(input logic       write,
                                           input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        req_chk_t chk;
        if (write)
            chk.illegal_f3 = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        else
            chk.illegal_f3 = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                               funct3 == F3_BU || funct3 == F3_HU);
        chk.misaligned = ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) ||
                         ((funct3 == F3_W) && (addr_lo != 2'b00));
        return chk;
    endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Selects the addressed byte/halfword lane of a RAM word and sign- or zero-extends it.
module mem_load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  byte_off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[{byte_off_i, 3'b000} +: 8];
        half_v = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data_o = {24'd0, byte_v};
            F3_H:    data_o = {{16{half_v[15]}}, half_v};
            F3_HU:   data_o = {16'd0, half_v};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the load/store channel: one request in flight, fixed access
// latency, byte-lane stores and extended loads on a word-organised RAM.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    mem_rsp_state_t state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    logic           wr_q;
    logic [2:0]     f3_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;

    logic [31:0]    mem [DEPTH_WORDS];
    logic [AW-1:0]  word_idx;
    logic [31:0]    rd_word;
    logic [31:0]    load_data;
    logic [31:0]    wr_lanes;
    logic [3:0]     be;
    logic           accept;
    logic           access;
    logic           req_bad;
    req_chk_t       chk;

    assign req_ready_o = (state_q == ST_IDLE) && rst_n_i;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    assign accept  = req_valid_i && req_ready_o;
    assign chk     = legal_req(req_write_i, req_funct3_i, req_addr_i[1:0]);
    assign req_bad = chk.misaligned || chk.illegal_f3 || (req_addr_i[31:2] >= 30'(DEPTH_WORDS));
    assign access  = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    assign word_idx = addr_q[AW+1:2];
    assign rd_word  = mem[word_idx];

    mem_load_extend u_load_extend (
        .word_i     (rd_word),
        .byte_off_i (addr_q[1:0]),
        .funct3_i   (f3_q),
        .data_o     (load_data)
    );

    always_comb begin
        be       = 4'b0000;
        wr_lanes = wdata_q;
        case (f3_q)
            F3_B: begin
                be       = 4'b0001 << addr_q[1:0];
                wr_lanes = {4{wdata_q[7:0]}};
            end
            F3_H: begin
                be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata_q[15:0]}};
            end
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // RAM is not reset; the write fires only on the single WAIT edge with cnt==0.
    always_ff @(posedge clk_i) begin
        if (access && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    rdata_d = wr_q ? 32'd0 : load_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                    rdata_d = 32'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                wr_q    <= req_write_i;
                f3_q    <= req_funct3_i;
                addr_q  <= req_addr_i[AW+1:0];
                wdata_q <= req_wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: loads/stores of every width, error paths,
// response backpressure and reset during an access.
module tb_data_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err)
    );

    always #5 clk = ~clk;

    // lat = clock edges after the acceptance edge until rsp_valid is seen (0 = already high).
    task automatic txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout addr=%h: req_ready still %b, need 1", addr, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got %b need 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_rsp_rdata got %h need 0", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_err got %b need 0", rsp_err); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready got %b need 0", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_req_ready got %b need 1", req_ready); end
    endtask

    task automatic test_word();
        logic [31:0] d; logic e; int l;
        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, e, l);
        n_cmp++; if (e !== 1'b0 || d !== 32'd0) begin n_bad++; $display("FAIL sw_rsp got err=%b rdata=%h need 0/0", e, d); end
        n_cmp++; if (l != LAT) begin n_bad++; $display("FAIL sw_latency got %0d need %0d", l, LAT); end
        txn(1'b0, 3'b010, 32'h10, 32'h0, d, e, l);
        n_cmp++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_data got %h need deadbeef", d); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL lw_err got %b need 0", e); end
        n_cmp++; if (l != LAT) begin n_bad++; $display("FAIL lw_latency got %0d need %0d", l, LAT); end
    endtask

    task automatic test_byte();
        logic [31:0] d; logic e; int l;
        txn(1'b1, 3'b000, 32'h11, 32'h000000A5, d, e, l);
        txn(1'b0, 3'b010, 32'h10, 32'h0, d, e, l);
        n_cmp++; if (d !== 32'hDEADA5EF) begin n_bad++; $display("FAIL sb_then_lw got %h need deada5ef", d); end
        txn(1'b0, 3'b000, 32'h11, 32'h0, d, e, l);
        n_cmp++; if (d !== 32'hFFFFFFA5) begin n_bad++; $display("FAIL lb got %h need ffffffa5", d); end
        txn(1'b0, 3'b100, 32'h11, 32'h0, d, e, l);
        n_cmp++; if (d !== 32'h000000A5) begin n_bad++; $display("FAIL lbu got %h need 000000a5", d); end
    endtask

    task automatic test_half();
        logic [31:0] d; logic e; int l;
        txn(1'b1, 3'b001, 32'h12, 32'h00008001, d, e, l);
        txn(1'b0, 3'b001, 32'h12, 32'h0, d, e, l);
        n_cmp++; if (d !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh got %h need ffff8001", d); end
        txn(1'b0, 3'b101, 32'h12, 32'h0, d, e, l);
        n_cmp++; if (d !== 32'h00008001) begin n_bad++; $display("FAIL lhu got %h need 00008001", d); end
        txn(1'b0, 3'b010, 32'h10, 32'h0, d, e, l);
        n_cmp++; if (d !== 32'h8001A5EF) begin n_bad++; $display("FAIL sh_then_lw got %h need 8001a5ef", d); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e; int l;
        txn(1'b0, 3'b010, 32'h13, 32'h0, d, e, l);
        n_cmp++; if (e !== 1'b1 || d !== 32'd0) begin n_bad++; $display("FAIL lw_misaligned got err=%b rdata=%h need 1/0", e, d); end
        n_cmp++; if (l != 0) begin n_bad++; $display("FAIL err_latency got %0d need 0", l); end
        txn(1'b1, 3'b010, 32'h14, 32'h0BADF00D, d, e, l);
        txn(1'b1, 3'b001, 32'h15, 32'h0000FFFF, d, e, l);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL sh_misaligned_err got %b need 1", e); end
        txn(1'b0, 3'b010, 32'h14, 32'h0, d, e, l);
        n_cmp++; if (d !== 32'h0BADF00D) begin n_bad++; $display("FAIL sh_misaligned_mem got %h need 0badf00d", d); end
        txn(1'b0, 3'b011, 32'h10, 32'h0, d, e, l);
        n_cmp++; if (e !== 1'b1 || d !== 32'd0) begin n_bad++; $display("FAIL load_f3_011 got err=%b rdata=%h need 1/0", e, d); end
        txn(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, d, e, l);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL store_f3_100 got %b need 1", e); end
        txn(1'b0, 3'b010, 32'h10, 32'h0, d, e, l);
        n_cmp++; if (d !== 32'h8001A5EF) begin n_bad++; $display("FAIL illegal_store_mem got %h need 8001a5ef", d); end
        txn(1'b1, 3'b010, 32'h0, 32'h11111111, d, e, l);
        txn(1'b1, 3'b010, 32'(4 * DEPTH), 32'h22222222, d, e, l);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL sw_out_of_range got %b need 1", e); end
        txn(1'b0, 3'b010, 32'h0, 32'h0, d, e, l);
        n_cmp++; if (d !== 32'h11111111) begin n_bad++; $display("FAIL oor_alias_mem got %h need 11111111", d); end
    endtask

    task automatic test_backpressure();
        int n;
        logic hold_ok;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        // A second request waits on the channel while the response is stalled.
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            hold_ok = (rsp_valid === 1'b1) && (rsp_rdata === 32'h8001A5EF) && (req_ready === 1'b0);
            n_cmp++;
            if (!hold_ok) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d got valid=%b rdata=%h ready=%b need 1/8001a5ef/0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_release got valid=%b rdata=%h ready=%b need 0/0/1", rsp_valid, rsp_rdata, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_next_accept ready got %b need 0", req_ready); end
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        n_cmp++; if (n != LAT || rsp_rdata !== 32'h0BADF00D) begin
            n_bad++; $display("FAIL bp_next_rsp got lat=%0d rdata=%h need %0d/0badf00d", n, rsp_rdata, LAT);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e; int l;
        logic stray;
        txn(1'b1, 3'b010, 32'h20, 32'h0, d, e, l);
        txn(1'b0, 3'b010, 32'h20, 32'h0, d, e, l);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL pre_reset_lw got %h need 0", d); end
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_outputs got valid=%b rdata=%h err=%b ready=%b need 0/0/0/0",
                              rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0) stray = 1'b1;
        end
        n_cmp++; if (stray !== 1'b0) begin n_bad++; $display("FAIL stray_rsp_valid got %b need 0", stray); end
        txn(1'b0, 3'b010, 32'h20, 32'h0, d, e, l);
        n_cmp++; if (d !== 32'd0 || e !== 1'b0) begin n_bad++; $display("FAIL post_reset_lw got %h err=%b need 0/0", d, e); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
